// File: rtl/btn_debounce_oneshot.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM with settle counter,
// and a single-cycle pulse for each accepted press.
module btn_debounce_oneshot #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       pulse_out,
   output logic       level_out,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_HIGH = 2'b01,
      HIGH      = 2'b10,
      WAIT_LOW  = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             level_q, level_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
      end
   end

   always_comb begin
      s1_d    = btn_in;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      level_d = level_q;
      // The terminal compare is checked before the increment so cnt never wraps.
      case (state_q)
         IDLE: begin
            if (s2_q) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!s2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
               pulse_d = 1'b1;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s2_q) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
            end
         end
         WAIT_LOW: begin
            // Release bounce returns to HIGH without a pulse; level stays high.
            if (s2_q) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign pulse_out = pulse_q;
   assign level_out = level_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_btn_debounce_oneshot.sv
// Bench for btn_debounce_oneshot: vector table, directed corner sequences and
// randomized button activity compared against a run-length reference model.
module tb_btn_debounce_oneshot;

   localparam int D     = 4;
   localparam int CNT_W = 3;

   logic       clk;
   logic       rst;
   logic       btn_in;
   logic       pulse_out;
   logic       level_out;
   logic [1:0] state_dbg;

   btn_debounce_oneshot #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .pulse_out(pulse_out),
      .level_out(level_out),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: the debounced level flips once the synchronised input has
   // disagreed with it for D+1 consecutive samples; a rising flip is the pulse.
   logic m_s1, m_s2, m_level, m_pulse;
   int   m_run;
   int   pulses;
   logic [1:0] ctr;

   function automatic logic [1:0] model_state();
      if (m_level) return (m_run > 0) ? 2'b11 : 2'b10;
      else         return (m_run > 0) ? 2'b01 : 2'b00;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step(input logic r, input logic b);
      rst    = r;
      btn_in = b;
      @(posedge clk);
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_run = 0;
      end else begin
         m_pulse = 1'b0;
         if (m_s2 != m_level) m_run++;
         else m_run = 0;
         if (m_run == D + 1) begin
            m_level = ~m_level;
            m_pulse = m_level;
            m_run   = 0;
         end
         m_s2 = m_s1;
         m_s1 = b;
      end
      #1;
      check("model", {4'b0, pulse_out, level_out, state_dbg},
            {4'b0, m_pulse, m_level, model_state()});
      if (pulse_out === 1'b1) begin
         pulses++;
         ctr = ctr + 2'd1;
      end
   endtask

   typedef struct {
      logic       rst;
      logic       btn;
      logic       pulse;
      logic       level;
      logic [1:0] state;
   } vec_t;

   vec_t vecs[18];

   initial begin
      int p0, k, hit, falls;
      logic prev_lvl, bad_state, lvl;

      // Clean press and release: rise at E0, pulse after E6, release symmetric.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

      rst = 1'b1; btn_in = 1'b0; pulses = 0; ctr = 2'd0;
      m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_run = 0;

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].rst, vecs[i].btn);
         check($sformatf("vec%0d", i), {4'b0, pulse_out, level_out, state_dbg},
               {4'b0, vecs[i].pulse, vecs[i].level, vecs[i].state});
         $display("vec %0d rst=%b btn=%b -> pulse=%b level=%b state=%b", i,
                  vecs[i].rst, vecs[i].btn, pulse_out, level_out, state_dbg);
      end

      // Fast toggle every 2 cycles: never accepted, never leaves IDLE/WAIT_HIGH.
      p0 = pulses; bad_state = 1'b0;
      for (int i = 0; i < 32; i++) begin
         step(1'b0, ((i / 2) % 2) == 0);
         if (state_dbg[1] !== 1'b0) bad_state = 1'b1;
      end
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
      check("toggle_pulses", 8'(pulses - p0), 8'd0);
      check("toggle_states", {7'b0, bad_state}, 8'd0);
      $display("fast toggle: pulses=%0d", pulses - p0);

      // Press bounce 1,0,1,1,0 then hold: single pulse 7 edges after final rise.
      p0 = pulses;
      step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
      step(1'b0, 1'b1); step(1'b0, 1'b0);
      hit = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b1);
         if (pulse_out === 1'b1 && hit == 0) hit = i;
      end
      check("bounce_latency", 8'(hit), 8'd7);
      check("bounce_pulses", 8'(pulses - p0), 8'd1);
      // Release bounce 0,1,0 then hold low: level falls once, no pulse.
      p0 = pulses; falls = 0; prev_lvl = level_out;
      for (int i = 0; i < 23; i++) begin
         lvl = (i == 1);
         step(1'b0, lvl);
         if (prev_lvl === 1'b1 && level_out === 1'b0) falls++;
         prev_lvl = level_out;
      end
      check("release_pulses", 8'(pulses - p0), 8'd0);
      check("release_falls", 8'(falls), 8'd1);
      check("release_level", {7'b0, level_out}, 8'd0);
      $display("bounce: latency=%0d release_falls=%0d", hit, falls);

      // Long hold: one pulse, downstream counter advances by exactly one.
      p0 = pulses;
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
      check("hold_pulses", 8'(pulses - p0), 8'd1);
      $display("long hold: pulses=%0d", pulses - p0);

      // Reset with the count at its terminal value aborts the press.
      step(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      check("pre_abort_state", {6'b0, state_dbg}, 8'h01);
      step(1'b1, 1'b1);
      check("abort_outputs", {4'b0, pulse_out, level_out, state_dbg}, 8'h00);
      hit = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b1);
         if (pulse_out === 1'b1 && hit == 0) hit = i;
      end
      check("post_reset_latency", 8'(hit), 8'd7);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
      $display("reset abort: post-reset pulse at edge %0d", hit);

      // Five spaced presses into a 2-bit counter: 00->01->10->11->00->01.
      ctr = 2'd0; p0 = pulses;
      for (int n = 1; n <= 5; n++) begin
         for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
         for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
         check($sformatf("ctr_after_%0d", n), {6'b0, ctr}, 8'(n % 4));
         $display("press %0d: counter=%b", n, ctr);
      end
      check("five_pulses", 8'(pulses - p0), 8'd5);

      // Randomized runs of random length with occasional reset.
      for (int r = 0; r < 400; r++) begin
         lvl = 1'($urandom_range(0, 1));
         k   = $urandom_range(1, 12);
         for (int i = 0; i < k; i++) step(($urandom_range(0, 63) == 0), lvl);
      end
      $display("random phase done");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/btn_debounce_oneshot.md
# btn_debounce_oneshot

Input-conditioning stage that sits directly upstream of the 2-bit up counter and drives its `x` count-enable input. It takes a raw, asynchronous, bouncy push-button level and synchronises it into `clk`. It debounces it with a 4-state FSM and cycle counter. Each accepted press produces exactly one single-cycle `pulse_out`, so the counter advances once per physical press regardless of hold time or contact bounce.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples (after the first) the input must stay at a new level before it is accepted; legal range 1..2^CNT_W (board builds use a large value, benches use 4).
- `CNT_W`, default 3: debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- `clk`  input  1  system clock, rising-edge active; all state updates on this edge.
- `rst`  input  1  synchronous, active-high reset, sampled on rising `clk`.
- `btn_in`  input  1  raw button level, asynchronous to `clk`, may bounce.
- `pulse_out`  output  1  one-cycle high pulse per accepted press; connects to counter `x`.
- `level_out`  output  1  debounced button level.
- `state_dbg`  output  2  current FSM state, for bench and ILA visibility.

## Operation
- Synchroniser: two flops, `s1 <= btn_in`, `s2 <= s1`; the FSM and counter see only `s2`.
- Counter `cnt` [CNT_W-1:0]: cleared to 0 on every FSM state change; increments only in the WAIT states while `s2` holds the candidate level.
- FSM encoding: IDLE=2'b00, WAIT_HIGH=2'b01, HIGH=2'b10, WAIT_LOW=2'b11; `state_dbg` is the state register.
- IDLE (stable low): `s2`=1 -> WAIT_HIGH, `cnt`<=0; else stay.
- WAIT_HIGH: `s2`=0 -> IDLE (bounce rejected, no pulse); `s2`=1 and `cnt`==DEBOUNCE_CYCLES-1 -> HIGH, `pulse_out`<=1, `level_out`<=1; otherwise `cnt`<=`cnt`+1.
- HIGH (stable high): `s2`=0 -> WAIT_LOW, `cnt`<=0; else stay. Holding the button produces no further pulses.
- WAIT_LOW: `s2`=1 -> HIGH (release bounce rejected, no pulse, `level_out` stays 1); `s2`=0 and `cnt`==DEBOUNCE_CYCLES-1 -> IDLE, `level_out`<=0; otherwise `cnt`<=`cnt`+1.
- `pulse_out` is registered, high only in the cycle after the WAIT_HIGH->HIGH transition edge, and cleared on every other edge. Release never pulses.
- `cnt` never wraps. The terminal compare takes priority over the increment, so `cnt` stops at DEBOUNCE_CYCLES-1.

## Timing
- Reset values (after a rising edge with `rst`=1): `s1`=0, `s2`=0, state=IDLE, `cnt`=0, `pulse_out`=0, `level_out`=0, `state_dbg`=2'b00. Reset overrides all other behaviour.
- Press latency: `btn_in` rises before edge E0 and stays high. `s2`=1 after E1. IDLE->WAIT_HIGH at E2. `pulse_out` and `level_out` go high after edge E(DEBOUNCE_CYCLES+2). With the default of 4, they go high after E6, the 7th edge.
- `pulse_out` width: exactly 1 clk cycle, falling at E(DEBOUNCE_CYCLES+3).
- Acceptance requires DEBOUNCE_CYCLES+1 consecutive `s2` samples at the new level: E2 through E(DEBOUNCE_CYCLES+2).
- Release latency is symmetric. `level_out` falls after E(DEBOUNCE_CYCLES+2), counted from the `btn_in` fall.
- Minimum press-to-press spacing is 2*(DEBOUNCE_CYCLES+1) cycles of clean levels. Anything faster is merged or rejected, never double-counted.
- Button held high through reset release: the first cycle out of reset sees IDLE with a high input. This is treated as a new press and pulses after the normal latency.
- Reset asserted mid-WAIT_HIGH: the press is aborted and no pulse occurs, even if the count was at its terminal value.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, 10 ns clk: `btn_in` 0->1 before edge E0, held for 20 cycles, then released -> exactly one `pulse_out` high in the cycle after E6. `level_out` goes 1 after E6 and falls 7 edges after release. `state_dbg` walks 00,01,10,11,00.
- Fast toggle, `btn_in` inverting every 2 cycles for 32 cycles -> `pulse_out` stays 0 throughout. `state_dbg` alternates only between 00 and 01.
- Bounce then settle: `btn_in` 1,0,1,1,0 at one-cycle steps, then held high -> exactly one pulse, 7 edges after the final rise. Release bounce 0,1,0 followed by hold-low -> no pulse, and `level_out` falls once.
- Long hold of 100 cycles -> one pulse only. Downstream counter `state` advances by exactly 1.
- Reset mid-WAIT_HIGH: `rst`=1 at cycle 4 of the wait with `btn_in` still high -> all outputs 0 the cycle after. Release `rst` with `btn_in` high -> a single pulse 7 edges later.
- Five well-spaced presses (30 cycles high, 30 low) feeding the counter -> 5 pulses, and the counter goes 00->01->10->11->00->01.
